// File: rtl/cic_decimator.sv
// Third-order CIC decimator (R = 2**DEC_LOG2): full-rate integrators, decimated comb, 4-clk comb/out pipeline.
// Optional CIC_ROUND_EN: round half up with positive saturation before slicing; otherwise plain truncation.
module cic_decimator #(
    parameter int INPUT_WIDTH  = 12,
    parameter int OUTPUT_WIDTH = 12,
    parameter int DEC_LOG2     = 12
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic signed [INPUT_WIDTH-1:0]  in_data,
    input  logic                           in_valid,
    output logic signed [OUTPUT_WIDTH-1:0] out_data,
    output logic                           out_valid
);

    localparam int REG_WIDTH = INPUT_WIDTH + 3 * DEC_LOG2;

    logic signed [REG_WIDTH-1:0]    in_ext;
    logic signed [REG_WIDTH-1:0]    i1, i2, i3;
    logic signed [REG_WIDTH-1:0]    dec_s;
    logic signed [REG_WIDTH-1:0]    c1, c2, c3;
    logic signed [REG_WIDTH-1:0]    d1, d2, d3;
    logic [DEC_LOG2-1:0]            dec_cnt;
    logic                           wrap;
    logic                           comb_go, v1, v2, v3;
    logic signed [OUTPUT_WIDTH-1:0] scaled;

    always_comb begin
        in_ext = REG_WIDTH'(in_data);
        wrap   = in_valid && (dec_cnt == '1);
    end

`ifdef CIC_ROUND_EN
    localparam logic [REG_WIDTH:0] HALF = {{REG_WIDTH{1'b0}}, 1'b1} << (REG_WIDTH - OUTPUT_WIDTH - 1);

    logic [REG_WIDTH:0] rounded;
    logic               unused_bits;

    // One guard bit above c3: rounding can only push a positive value past the top.
    always_comb begin
        rounded = {c3[REG_WIDTH-1], c3} + HALF;
        if (!rounded[REG_WIDTH] && rounded[REG_WIDTH-1])
            scaled = {1'b0, {(OUTPUT_WIDTH-1){1'b1}}};
        else
            scaled = rounded[REG_WIDTH-1 -: OUTPUT_WIDTH];
        unused_bits = ^rounded[REG_WIDTH-OUTPUT_WIDTH-1:0];
    end
`else
    logic unused_bits;

    always_comb begin
        scaled      = c3[REG_WIDTH-1 -: OUTPUT_WIDTH];
        unused_bits = ^c3[REG_WIDTH-OUTPUT_WIDTH-1:0];
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            i1        <= '0;
            i2        <= '0;
            i3        <= '0;
            dec_cnt   <= '0;
            dec_s     <= '0;
            comb_go   <= 1'b0;
            c1        <= '0;
            c2        <= '0;
            c3        <= '0;
            d1        <= '0;
            d2        <= '0;
            d3        <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            v3        <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (in_valid) begin
                i1      <= i1 + in_ext;
                i2      <= i2 + i1;
                i3      <= i3 + i2;
                dec_cnt <= dec_cnt + DEC_LOG2'(1);
            end
            if (wrap)
                dec_s <= i3;
            comb_go <= wrap;

            v1 <= comb_go;
            if (comb_go) begin
                c1 <= dec_s - d1;
                d1 <= dec_s;
            end
            v2 <= v1;
            if (v1) begin
                c2 <= c1 - d2;
                d2 <= c1;
            end
            v3 <= v2;
            if (v2) begin
                c3 <= c2 - d3;
                d3 <= c2;
            end

            out_valid <= v3;
            if (v3)
                out_data <= scaled;
        end
    end

endmodule
